// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = a - b - bin over WIDTH cycles with a start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             accept;
  logic [1:0]       step;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  assign accept = start && (state_q != RUN);
  // Upper bit of the 2-bit difference is the borrow into the next bit.
  assign step   = {1'b0, sa_q[0]} - {1'b0, sb_q[0]} - {1'b0, br_q};

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    sr_d   = sr_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    bout_d = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      sa_d  = a;
      sb_d  = b;
      br_d  = bin;
      cnt_d = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      sr_d  = {step[0], sr_q[WIDTH-1:1]};
      br_d  = step[1];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        d_d    = {step[0], sr_q[WIDTH-1:1]};
        bout_d = step[1];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d = (a_msb_q != b_msb_q) && (step[0] != a_msb_q);
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start yields WIDTH busy cycles then a one-cycle done
  // carrying the integer result of a - b - bin.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_d = '0, p_d = '0;
  bit           m_bout = 1'b0, p_bout = 1'b0;
  bit           m_ovf = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_d = '0; m_bout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_d = p_d; m_bout = p_bout; m_ovf = p_ovf;
        end
      end else if (start) begin
        int diff;
        diff   = int'(a) - int'(b) - int'(bin);
        p_d    = W'(diff);
        p_bout = (int'(a) < int'(b) + int'(bin));
        p_ovf  = (a[W-1] != b[W-1]) && (p_d[W-1] != a[W-1]);
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_left > 0);
      check("model_done", done, m_done);
      check("model_d", d, m_d);
      check("model_bout", bout, m_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("model_ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input logic st);
    a = av; b = bv; bin = bi; start = st;
  endtask

  task automatic scramble();
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin found = 1; break; end
    end
    check({name, "_done_seen"}, found, 1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
    @(posedge clk); #1 drive(av, bv, bi, 1'b1);
    @(posedge clk); #1 start = 1'b0; scramble();
    wait_done(name);
    check({name, "_d"}, d, ed);
    check({name, "_bout"}, bout, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({name, "_ovf"}, ovf, eo);
`else
    if (eo) ;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #1 chk_en = 1'b1;
    #20;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency: start in cycle 0, busy cycles 1..8, done in 9, gone in 10.
    @(posedge clk); #1 drive(8'h35, 8'h12, 1'b0, 1'b1);
    @(posedge clk); #1 start = 1'b0; scramble();
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check($sformatf("lat_busy_c%0d", i), busy, 1);
      check($sformatf("lat_nodone_c%0d", i), done, 0);
    end
    @(negedge clk);
    check("lat_done_c9", done, 1);
    check("lat_busy_c9", busy, 0);
    check("lat_d", d, 8'h23);
    check("lat_bout", bout, 0);
    @(negedge clk);
    check("lat_done_c10", done, 0);
    check("lat_hold_d", d, 8'h23);

    run_op("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("bin", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);

    // Back-to-back: start held through DONE.
    @(posedge clk); #1 drive(8'hAA, 8'h55, 1'b0, 1'b1);
    @(posedge clk); #1 drive(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done("b2b1");
    check("b2b1_d", d, 8'h55);
    check("b2b1_bout", bout, 0);
    @(posedge clk); #1 start = 1'b0; scramble();
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_c%0d", i), busy, 1);
    end
    @(negedge clk);
    check("b2b2_done", done, 1);
    check("b2b2_d", d, 8'hFE);
    check("b2b2_bout", bout, 1);

    // Start during RUN is ignored.
    @(posedge clk); #1 drive(8'h35, 8'h12, 1'b0, 1'b1);
    @(posedge clk); #1 start = 1'b0; scramble();
    repeat (3) @(posedge clk);
    #1 drive(8'h01, 8'hF0, 1'b1, 1'b1);
    @(posedge clk); #1 start = 1'b0; scramble();
    wait_done("ign");
    check("ign_d", d, 8'h23);
    check("ign_bout", bout, 0);
    repeat (W + 2) begin
      @(negedge clk);
      check("ign_no_extra_done", done, 0);
    end

    // Reset in cycle 5 of RUN; d holds a nonzero result beforehand.
    @(posedge clk); #1 drive(8'h00, 8'h01, 1'b0, 1'b1);
    @(posedge clk); #1 start = 1'b0; scramble();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_d", d, 8'h00);
    check("mid_rst_bout", bout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("post_rst_idle", done | busy, 0);
    end
    run_op("after_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ovf_none", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
